image_uart_tx: RTL and testbench

Streams a stored image out of a block RAM over a UART serial line, one 8-bit pixel per 8N1 frame, in ascending address order. It is the transmit-side counterpart of the image receive path. It reads the original, processed or temp image BRAM (1-cycle read latency, 14-bit address, 8-bit data) and drives TxD back to the host PC.

---
 rtl/image_uart_pkg.sv | 19 +
 rtl/uart_tx_serializer.sv | 110 +++++++++++
 rtl/image_uart_tx.sv | 95 +++++++++
 tb/tb_image_uart_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_uart_pkg.sv
// rtl/image_uart_pkg.sv - shared image UART widths, default timing constants and state encoding
`timescale 1ns/1ps
package image_uart_pkg;
    localparam int IMG_ADDR_W       = 14;
    localparam int PIX_W            = 8;
    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_NUM_PIXELS   = 16384;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } tx_state_t;
endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - one UART frame per load; even parity slot under IMAGE_UART_TX_PARITY_EN
`timescale 1ns/1ps
module uart_tx_serializer
    import image_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PIX_W-1:0] data_in,
    output logic             tx,
    output logic             frame_done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_t        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [PIX_W-1:0]  shreg;
    logic              baud_wrap;
`ifdef IMAGE_UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign baud_wrap  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    // Asserted in the last cycle of the stop bit so the fetch side can react on the same edge.
    assign frame_done = (state == ST_STOP) && baud_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
`ifdef IMAGE_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shreg    <= data_in;
                        tx       <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_START;
`ifdef IMAGE_UART_TX_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                    end
                end
                ST_START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef IMAGE_UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[PIX_W-1:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef IMAGE_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/image_uart_tx.sv
// rtl/image_uart_tx.sv - streams an image BRAM out over UART; IMAGE_UART_TX_PARITY_EN selects 8E1
`timescale 1ns/1ps
module image_uart_tx
    import image_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int NUM_PIXELS   = DEF_NUM_PIXELS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [IMG_ADDR_W-1:0] addr,
    output logic                  rd_en,
    input  logic [PIX_W-1:0]      pixel,
    output logic                  TxD,
    output logic                  busy,
    output logic                  done
);
    localparam logic [IMG_ADDR_W-1:0] LAST_PIX = IMG_ADDR_W'(NUM_PIXELS - 1);

    tx_state_t             state;
    logic [IMG_ADDR_W-1:0] pix_cnt;
    logic                  load;
    logic                  frame_done;

    // BRAM data is valid during WAIT; the serializer captures it on the edge closing WAIT.
    assign load = (state == ST_WAIT);

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (pixel),
        .tx         (TxD),
        .frame_done (frame_done)
    );

    // ST_START here stands for "frame in flight"; the serializer walks the bit phases itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pix_cnt <= '0;
            addr    <= '0;
            rd_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                        addr  <= pix_cnt;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rd_en <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_START;
                end
                ST_START: begin
                    if (frame_done) begin
                        if (pix_cnt == LAST_PIX) begin
                            pix_cnt <= '0;
                            addr    <= '0;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                            addr    <= pix_cnt + 1'b1;
                            rd_en   <= 1'b1;
                            state   <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    rd_en <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_image_uart_tx.sv
// tb/tb_image_uart_tx.sv - directed bench for image_uart_tx (single-pixel and four-pixel instances)
`timescale 1ns/1ps
module tb_image_uart_tx;
    localparam int CPB = 4;
`ifdef IMAGE_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [13:0] addr1, addr4;
    logic        rd1, rd4;
    logic [7:0]  pix1 = 8'h00;
    logic [7:0]  pix4 = 8'h00;
    logic        tx1, tx4, busy1, busy4, done1, done4;
    logic [7:0]  mem1 [0:3];
    logic [7:0]  mem4 [0:3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd1) pix1 <= mem1[addr1[1:0]];
        if (rd4) pix4 <= mem4[addr4[1:0]];
    end

    image_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_PIXELS(1)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .addr(addr1), .rd_en(rd1),
        .pixel(pix1), .TxD(tx1), .busy(busy1), .done(done1)
    );

    image_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_PIXELS(4)) dut4 (
        .clk(clk), .reset(rst_n), .start(start4), .addr(addr4), .rd_en(rd4),
        .pixel(pix4), .TxD(tx4), .busy(busy4), .done(done4)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // UART receiver and bus monitor for the four-pixel instance
    int          ncyc = 0;
    logic        rx_act = 1'b0;
    int          rx_cnt = 0;
    int          idx;
    logic [7:0]  rx_sh = 8'h00;
    logic [7:0]  byte_q [$];
    int          fall_q [$];
    logic [13:0] addr_q [$];
    int          fetch_q [$];
    int          done_cnt = 0;
    int          done_t = 0;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            rx_act = 1'b0;
        end else begin
            if (rd4) begin
                addr_q.push_back(addr4);
                fetch_q.push_back(ncyc);
            end
            if (done4) begin
                done_cnt++;
                done_t = ncyc;
            end
            if (!rx_act) begin
                if (tx4 == 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                    fall_q.push_back(ncyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2) begin
                    idx = rx_cnt / CPB;
                    if (idx >= 1 && idx <= 8) rx_sh[idx-1] = tx4;
                    if (idx == NBITS - 1) begin
                        byte_q.push_back(rx_sh);
                        rx_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic clear_mon;
        byte_q.delete();
        fall_q.delete();
        addr_q.delete();
        fetch_q.delete();
        done_cnt = 0;
    endtask

    task automatic run_single(input logic [7:0] b, input logic par, input string tag);
        logic [NBITS-1:0] exp_bits;
        logic [3:0]       s;
        int               dones;
        exp_bits    = '0;
        exp_bits[0] = 1'b0;
        for (int i = 1; i <= 8; i++) exp_bits[i] = b[i-1];
        exp_bits[9] = par;
        exp_bits[NBITS-1] = 1'b1;
        dones = 0;
        mem1[0] = b;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        check({tag, "_fetch_rd_en"}, rd1, 1);
        check({tag, "_fetch_addr"}, addr1, 0);
        check({tag, "_fetch_busy"}, busy1, 1);
        tick;
        check({tag, "_wait_rd_en"}, rd1, 0);
        check({tag, "_wait_txd"}, tx1, 1);
        for (int i = 0; i < NBITS; i++) begin
            for (int j = 0; j < CPB; j++) begin
                tick;
                s[j] = tx1;
                if (done1) dones++;
            end
            check($sformatf("%s_bit%0d", tag, i), s, {4{exp_bits[i]}});
        end
        check({tag, "_no_early_done"}, dones, 0);
        tick;
        check({tag, "_done_pulse"}, done1, 1);
        check({tag, "_busy_in_done"}, busy1, 1);
        tick;
        check({tag, "_done_low"}, done1, 0);
        check({tag, "_busy_low"}, busy1, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0] exp_img [0:3];
    logic       changed;
    logic       got;
    logic       pulsed;

    initial begin
        exp_img[0] = 8'h00; exp_img[1] = 8'hFF; exp_img[2] = 8'h3C; exp_img[3] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            mem1[i] = 8'h00;
            mem4[i] = exp_img[i];
        end

        // reset and idle hold
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        check("rst_txd", tx1, 1);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_addr", addr1, 0);
        check("rst_rd_en", rd1, 0);
        check("rst_txd4", tx4, 1);
        changed = 1'b0;
        repeat (100) begin
            tick;
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || rd1 !== 1'b0 ||
                addr1 !== 14'd0 || tx4 !== 1'b1 || busy4 !== 1'b0 || rd4 !== 1'b0)
                changed = 1'b1;
        end
        check("idle_hold", changed, 0);

        // single pixel 0xA5
        run_single(8'hA5, 1'b0, "a5");

        // four-pixel image with a stray start during pixel 2
        clear_mon();
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        got = 1'b0;
        pulsed = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            if (!pulsed && addr_q.size() == 3) begin
                start4 = 1'b1;
                tick;
                tick;
                start4 = 1'b0;
                pulsed = 1'b1;
            end
            tick;
            if (done4) got = 1'b1;
        end
        check("img_done_seen", got, 1);
        check("img_busy_at_done", busy4, 1);
        tick;
        check("img_busy_after_done", busy4, 0);
        check("img_done_one_cycle", done4, 0);
        repeat (60) tick;
        check("img_byte_count", byte_q.size(), 4);
        check("img_done_count", done_cnt, 1);
        check("img_fetch_count", addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("img_byte%0d", i), (i < byte_q.size()) ? byte_q[i] : 32'hDEAD, exp_img[i]);
            check($sformatf("img_addr%0d", i), (i < addr_q.size()) ? addr_q[i] : 32'hDEAD, i);
        end
        for (int i = 1; i < 4; i++)
            check($sformatf("img_frame_spacing%0d", i),
                  (i < fall_q.size()) ? fall_q[i] - fall_q[i-1] : -1, FRAME + 2);
        check("img_period", (fetch_q.size() > 0) ? done_t - fetch_q[0] : -1, 4 * (FRAME + 2));

        // reset in the middle of pixel 1 data bits
        mem4[0] = 8'h5A;
        mem4[1] = 8'h00;
        clear_mon();
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick;
            if (fall_q.size() == 2) got = 1'b1;
        end
        check("rst_mid_second_frame_seen", got, 1);
        repeat (3 * CPB) tick;
        check("rst_mid_txd_low", tx4, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_txd_async", tx4, 1);
        check("rst_mid_busy", busy4, 0);
        check("rst_mid_addr", addr4, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        clear_mon();
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            tick;
            if (done4) got = 1'b1;
        end
        check("restart_done_seen", got, 1);
        tick;
        check("restart_first_addr", (addr_q.size() > 0) ? addr_q[0] : 32'hDEAD, 0);
        check("restart_first_byte", (byte_q.size() > 0) ? byte_q[0] : 32'hDEAD, 8'h5A);
        check("restart_second_byte", (byte_q.size() > 1) ? byte_q[1] : 32'hDEAD, 8'h00);
        check("restart_byte_count", byte_q.size(), 4);

`ifdef IMAGE_UART_TX_PARITY_EN
        run_single(8'h07, 1'b1, "p07");
        run_single(8'h03, 1'b0, "p03");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
